// File: rtl/wb_merge_queue_pkg.sv
// Shared writeback types (package combined_wire).
// Holds the register-write request format used by the execute/memory stages,
// the storage format of a writeback merge queue entry, and small helpers
// shared by the queue and its forwarding search.
package combined_wire;

    localparam int REG_AW = 5;
    localparam int WORD_W = 32;

    typedef logic [REG_AW-1:0] reg_addr;
    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic    reg_write_enable;
        reg_addr reg_dest_addr;
        word_t   reg_write_data;
    } reg_writer;

    // A stored entry is always a real write; its validity comes from
    // lying inside the head..head+count-1 occupancy window.
    typedef struct packed {
        reg_addr dest;
        word_t   data;
    } wbq_entry_t;

    // Bound of the youngest-match search: an entry at age offset `age`
    // from the head is live only while it is below the occupancy count.
    function automatic logic wbq_age_live(input int unsigned age, input int unsigned count);
        return age < count;
    endfunction

    // Writes to x0 or with the enable low never reach the register file.
    function automatic logic wbq_storable(input reg_writer w);
        return w.reg_write_enable && (w.reg_dest_addr != '0);
    endfunction

endpackage

// File: rtl/wb_merge_queue_if.sv
// Writeback merge queue bus.
// Bundles the producer channels, the register-file retire port and the
// forwarding lookup ports.
//   master : producers / register file / decode side
//   slave  : the queue itself
interface wb_merge_queue_if #(
    parameter int NUM_CH = 2,
    parameter int NUM_RD = 2
);
    import combined_wire::*;

    logic [NUM_CH-1:0] in_valid;
    reg_writer         in_wr [NUM_CH];
    logic [NUM_CH-1:0] in_ready;

    logic              out_valid;
    reg_writer         out_wr;
    logic              out_ready;

    reg_addr           rd_addr [NUM_RD];
    logic [NUM_RD-1:0] rd_hit;
    word_t             rd_data [NUM_RD];

    modport master (
        output in_valid, in_wr, out_ready, rd_addr,
        input  in_ready, out_valid, out_wr, rd_hit, rd_data
    );

    modport slave (
        input  in_valid, in_wr, out_ready, rd_addr,
        output in_ready, out_valid, out_wr, rd_hit, rd_data
    );
endinterface

// File: rtl/wb_merge_queue_age_match.sv
// wbq_age_match: youngest-pending-write lookup for one read address.
// Ports:
//   entries : queue storage array
//   head    : oldest entry slot
//   count   : number of occupied entries
//   addr    : register address being looked up
//   hit     : a live entry writes addr (never for x0)
//   data    : value of the youngest such entry, 0 when no hit
module wbq_age_match
    import combined_wire::*;
#(
    parameter int DEPTH = 4
) (
    input  wbq_entry_t                entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]  head,
    input  logic [$clog2(DEPTH):0]    count,
    input  reg_addr                   addr,
    output logic                      hit,
    output word_t                     data
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] slot;

    // Walking from oldest to youngest and letting later matches overwrite
    // earlier ones yields the same result as stopping at the first match
    // when scanning from tail-1 back to head.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        slot = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PW'(k);
            if (wbq_age_live(unsigned'(k), 32'(count)) && (addr != '0) &&
                (entries[slot].dest == addr)) begin
                hit  = 1'b1;
                data = entries[slot].data;
            end
        end
    end
endmodule

// File: rtl/wb_merge_queue.sv
// wb_merge_queue: age-ordered writeback merge queue in front of the register
// file. Accepts up to NUM_CH writes per cycle, retires one per cycle.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : synchronous clear of all entries
//   bus (slave)  : producer channels, retire port, forwarding lookups
//   count        : occupied entries
// Build option: define WB_FORWARD_EN to build the forwarding search;
// otherwise rd_hit/rd_data are tied to zero.
module wb_merge_queue
    import combined_wire::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 4,
    parameter int NUM_RD = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    wb_merge_queue_if.slave        bus,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    wbq_entry_t        mem_q [DEPTH];
    wbq_entry_t        mem_d [DEPTH];

    logic [NUM_CH-1:0] rdy_c;
    logic [31:0]       free_c, need_c, wr_n;
    logic [PW-1:0]     slot_c;
    logic              out_valid_c, deq;

    assign out_valid_c = (count_q != '0);
    assign deq         = out_valid_c && bus.out_ready;

    // Credit is the free space at the start of the cycle only; a dequeue in
    // the same cycle does not make room. Because `need_c` only grows, once a
    // channel is refused every later storable channel is refused too, so
    // the accepted requests are always a prefix and land in consecutive slots.
    always_comb begin
        mem_d  = mem_q;
        rdy_c  = '0;
        free_c = 32'(DEPTH) - 32'(count_q);
        need_c = '0;
        wr_n   = '0;
        slot_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rdy_c[i] = flush || !wbq_storable(bus.in_wr[i]) || (free_c > need_c);
            if (bus.in_valid[i] && wbq_storable(bus.in_wr[i])) begin
                if (!flush && (free_c > need_c)) begin
                    slot_c        = tail_q + PW'(wr_n);
                    mem_d[slot_c] = '{dest: bus.in_wr[i].reg_dest_addr,
                                      data: bus.in_wr[i].reg_write_data};
                    wr_n          = wr_n + 32'd1;
                end
                need_c = need_c + 32'd1;
            end
        end
    end

    always_comb begin
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(deq);
            tail_d  = tail_q + PW'(wr_n);
            count_d = count_q + CW'(wr_n) - CW'(deq);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is qualified by the occupancy window, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.in_ready  = rdy_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_wr    = out_valid_c ? '{reg_write_enable: 1'b1,
                                           reg_dest_addr:    mem_q[head_q].dest,
                                           reg_write_data:   mem_q[head_q].data}
                                       : '0;
    assign count         = count_q;

    logic [NUM_RD-1:0] hit_c;
    word_t             data_c [NUM_RD];

`ifdef WB_FORWARD_EN
    for (genvar r = 0; r < NUM_RD; r++) begin : g_fwd
        wbq_age_match #(.DEPTH(DEPTH)) u_match (
            .entries (mem_q),
            .head    (head_q),
            .count   (count_q),
            .addr    (bus.rd_addr[r]),
            .hit     (hit_c[r]),
            .data    (data_c[r])
        );
    end
`else
    logic unused_rd;
    always_comb begin
        unused_rd = 1'b0;
        for (int r = 0; r < NUM_RD; r++) begin
            hit_c[r]  = 1'b0;
            data_c[r] = '0;
            unused_rd = unused_rd ^ (^bus.rd_addr[r]);
        end
    end
`endif

    assign bus.rd_hit  = hit_c;
    assign bus.rd_data = data_c;

endmodule

// File: doc/wb_merge_queue.md
# wb_merge_queue

Parametrised writeback merge queue between the execute/memory stages and the register file. Accepts up to NUM_CH register-write requests per cycle, each a reg_writer, on independent valid/ready channels. Stores them in age order in a DEPTH-entry circular buffer and retires one per cycle to the register-file write port. Optionally forwards the youngest pending value for NUM_RD read addresses so decode need not stall on queued writes.

## Interface
Parameters:
- NUM_CH, 2: producer channels; channel 0 is oldest within a cycle.
- DEPTH, 4: queue entries; power of two, at least 2.
- NUM_RD, 2: forwarding lookup ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries.
- in_valid  in  NUM_CH  per-channel request valid.
- in_wr  in  NUM_CH x reg_writer  per-channel request.
- in_ready  out  NUM_CH  per-channel accept.
- out_valid  out  1  head entry present.
- out_wr  out  reg_writer  head entry; reg_write_enable equals out_valid.
- out_ready  in  1  register file consumes head.
- rd_addr  in  NUM_RD x reg_addr  lookup addresses.
- rd_hit  out  NUM_RD  pending write to rd_addr exists.
- rd_data  out  NUM_RD x word_t  youngest pending value for rd_addr.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- A request is droppable when reg_write_enable is 0 or reg_dest_addr is 0. Droppable requests handshake normally but are never stored and consume no slot.
- free = DEPTH - count, evaluated at the start of the cycle. A dequeue in the same cycle does not add credit.
- in_ready[i] = 1 when free exceeds the number of non-droppable valid requests on channels 0..i-1. It is always 1 for a droppable request.
- Accepted storable requests are written at consecutive tail slots in ascending channel order. The tail advances by the number written, modulo DEPTH.
- Dequeue happens when out_valid and out_ready are both high. The head advances by 1 modulo DEPTH.
- count_next = count + enq - deq. Enqueue and dequeue may occur in the same cycle. A full queue with out_ready high still refuses new storable requests that cycle.
- Forwarding scans valid stored entries from tail-1 back to head. The first entry whose reg_dest_addr equals rd_addr gives rd_data and rd_hit=1.
  - Lookup is purely combinational on stored state.
  - Requests entering in the current cycle are not visible to lookup.
  - rd_addr 0 never hits.
- flush: the next state has count 0 and head = tail = 0. Requests presented in the flush cycle are discarded even if in_ready is high. in_ready is driven high during flush.

## Timing
- Reset values: count 0, out_valid 0, out_wr all zero, rd_hit 0, rd_data 0, in_ready all 1. Pointers are 0.
- Reset assertion mid-operation clears state immediately and asynchronously. Pending entries are lost.
- Enqueue in cycle N makes the entry visible on out_wr and to lookup in cycle N+1. There is no enqueue-to-output bypass, so minimum latency is 1 cycle.
- Throughput is one retire per cycle. Sustained enqueue above 1 per cycle fills the queue within DEPTH cycles.
- Wrap-around: the pointer width is $clog2(DEPTH). Full and empty are distinguished by count, not by pointer equality.

## Configuration
- WB_FORWARD_EN defined: the forwarding search is built as specified.
- WB_FORWARD_EN undefined: rd_hit and rd_data are tied to 0, and no comparators are generated. The consumer must stall on pending writes instead.

## Structure
- reg_writer, reg_addr and word_t come from the shared package combined_wire.
- Add to combined_wire:
  - wbq_entry_t: dest, data (valid is implied by the occupancy range);
  - a helper for the youngest-match search bound.
- One sub-module, wbq_age_match: given the entry array, head, count and one address, returns hit and data. It is instantiated NUM_RD times under WB_FORWARD_EN.

## Test plan
- Single enqueue: ch0 {x5, 0xAA}, out_ready=1. Next cycle out_wr={x5, 0xAA, en=1}, then out_valid=0. count goes 0→1→0.
- Dual enqueue with stalled output, DEPTH=4, out_ready=0: two cycles of ch0 {x1,1} / ch1 {x2,2}. Then count=4, in_ready=00. Drain order is x1, x2, x1, x2.
- Partial accept: count=3, ch0 {x3,3} and ch1 {x4,4} both valid. in_ready=01; only x3 is stored; ch1 retries and is accepted the next cycle after one dequeue.
- Drop rule: ch0 {x0, 0x11, en=1} and ch1 {x7, 0x22, en=0}. Both have in_ready=1, count stays 0, and out_valid stays 0.
- Forwarding: enqueue {x9,0x10}, then {x9,0x20}. rd_addr=x9 gives hit=1 and data=0x20. After both dequeue, hit=0. Without WB_FORWARD_EN, hit=0 throughout.
- Flush and reset: with count=3, flush=1 gives count=0 next cycle. reset_n low mid-burst immediately gives out_valid=0 and count=0.
